// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer display path.
//   SEG_BLANK   : active-low pattern with every segment off
//   SEG_DASH    : active-low pattern lighting only segment g
//   SEG_TABLE   : active-low {g,f,e,d,c,b,a} patterns for BCD digits 0..9
//   digit_idx_t : which of the four display positions is being scanned
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Element [k] holds the pattern for digit k (element 9 is written first).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Scan order: rightmost digit first, leftmost position is always blank.
    typedef enum logic [1:0] {
        DIGIT_SEC_UNI = 2'd0,
        DIGIT_SEC_DEC = 2'd1,
        DIGIT_MIN     = 2'd2,
        DIGIT_BLANK   = 2'd3
    } digit_idx_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd : 4-bit BCD value
//   seg : active-low segments {g,f,e,d,c,b,a}; values above 9 show a dash
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/timer_display.sv
// ---------------------------------------------------------------------------
// timer_display
// Multiplexed four-digit driver for an M:SS countdown timer. A prescaler
// sets how long each digit stays lit; the BCD inputs are sampled once per
// scan frame so a digit never changes halfway through a frame.
//
// Parameters:
//   SCAN_DIV     : clock cycles per digit (2..65535)
//   BLINK_FRAMES : scan frames per blink half-period (1..255)
// Ports:
//   clock       : rising-edge clock
//   Cn          : synchronous active-low reset
//   sec_unidade : BCD seconds units
//   sec_decimal : BCD seconds tens
//   min         : BCD minutes
//   zero        : timer has reached 0:00 (only used with blink enabled)
//   an          : active-low digit enables, an[0] = rightmost digit
//   seg         : active-low segments {g,f,e,d,c,b,a}
//   dp_n        : active-low colon/decimal point, lit with the minutes digit
//
// Build option: define TIMER_DISPLAY_BLINK_EN to blank the whole display
// on alternating groups of BLINK_FRAMES frames while zero is high.
// ---------------------------------------------------------------------------
module timer_display
    import timer_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic       clock,
    input  logic       Cn,
    input  logic [3:0] sec_unidade,
    input  logic [3:0] sec_decimal,
    input  logic [3:0] min,
    input  logic       zero,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp_n
);

    localparam logic [15:0] TICK_AT = 16'(SCAN_DIV - 1);

    logic [15:0] prescaler;
    digit_idx_t  index;
    digit_idx_t  index_next;
    logic [11:0] snapshot;
    logic        tick;
    logic        frame_wrap;
    logic [3:0]  nibble;
    logic [6:0]  digit_seg;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;
    logic        dp_next;
    logic        blank_all;

    assign tick       = (prescaler == TICK_AT);
    assign frame_wrap = tick && (index == DIGIT_BLANK);

    // Digit index advances one position per tick and wraps 3 -> 0.
    always_comb begin
        index_next = index;
        if (tick) begin
            index_next = digit_idx_t'(index + 2'd1);
        end
    end

    // Pick the snapshot nibble for the digit currently being scanned.
    always_comb begin
        nibble = 4'd0;
        case (index)
            DIGIT_SEC_UNI: nibble = snapshot[3:0];
            DIGIT_SEC_DEC: nibble = snapshot[7:4];
            DIGIT_MIN:     nibble = snapshot[11:8];
            default:       nibble = 4'd0;
        endcase
    end

    bcd_to_seg7 u_decode (
        .bcd (nibble),
        .seg (digit_seg)
    );

    // Next output values; the blank position still enables its anode.
    always_comb begin
        an_next        = 4'b1111;
        an_next[index] = 1'b0;
        seg_next       = (index == DIGIT_BLANK) ? SEG_BLANK : digit_seg;
        dp_next        = (index != DIGIT_MIN);
        if (blank_all) begin
            an_next = 4'b1111;
        end
    end

    // Scan state, input snapshot and registered outputs; reset wins over
    // any tick or capture on the same edge.
    always_ff @(posedge clock) begin
        if (!Cn) begin
            prescaler <= 16'd0;
            index     <= DIGIT_SEC_UNI;
            snapshot  <= 12'd0;
            an        <= 4'b1111;
            seg       <= SEG_BLANK;
            dp_n      <= 1'b1;
        end else begin
            prescaler <= tick ? 16'd0 : prescaler + 16'd1;
            index     <= index_next;
            if (frame_wrap) begin
                snapshot <= {min, sec_decimal, sec_unidade};
            end
            an   <= an_next;
            seg  <= seg_next;
            dp_n <= dp_next;
        end
    end

`ifdef TIMER_DISPLAY_BLINK_EN
    localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] frame_cnt;
    logic       blink_phase;

    // Gating with zero lets normal scanning return on the very edge where
    // zero is seen low, before the phase register has been cleared.
    assign blank_all = zero && blink_phase;

    // Count frame wraps while zero is high and flip the phase every
    // BLINK_FRAMES wraps; zero low restarts the pattern from phase 0.
    always_ff @(posedge clock) begin
        if (!Cn || !zero) begin
            frame_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= 8'd0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_zero;

    assign unused_zero = zero;
    assign blank_all   = 1'b0;
`endif

endmodule

// File: tb/tb_timer_display.sv
// ---------------------------------------------------------------------------
// tb_timer_display
// Self-checking bench for timer_display (SCAN_DIV = 4, BLINK_FRAMES = 2).
// The reference model works from the count of edges since reset: the digit
// shown after edge n is ((n-1)/SCAN_DIV) mod 4, and inputs are captured on
// every edge that is a multiple of one full frame (4*SCAN_DIV edges).
// With TIMER_DISPLAY_BLINK_EN the model blanks anodes when the number of
// wraps seen since zero rose, divided by BLINK_FRAMES, is odd.
// ---------------------------------------------------------------------------
module tb_timer_display;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic       clock = 1'b0;
    logic       Cn = 1'b0;
    logic [3:0] sec_unidade = 4'd0;
    logic [3:0] sec_decimal = 4'd0;
    logic [3:0] min = 4'd0;
    logic       zero = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          n_edges = 0;
    logic [11:0] m_snap = 12'd0;
    int          wraps_z = 0;

    always #5 clock = ~clock;

    timer_display #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock       (clock),
        .Cn          (Cn),
        .sec_unidade (sec_unidade),
        .sec_decimal (sec_decimal),
        .min         (min),
        .zero        (zero),
        .an          (an),
        .seg         (seg),
        .dp_n        (dp_n)
    );

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [6:0] observed,
                               input logic [6:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%b expected=%b edge=%0d t=%0t",
                     tag, observed, expected, n_edges, $time);
        end
    endtask

    // Standard seven-segment patterns, dash for anything outside 0..9.
    function automatic logic [6:0] refSeg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model over the edge and check
    // all three outputs shortly after the edge.
    task automatic applyStimulus(input logic rst_n, input logic [3:0] u,
                                 input logic [3:0] d, input logic [3:0] m,
                                 input logic z);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         idx;
        Cn          = rst_n;
        sec_unidade = u;
        sec_decimal = d;
        min         = m;
        zero        = z;
        @(posedge clock);
        if (!rst_n) begin
            n_edges = 0;
            m_snap  = 12'd0;
            wraps_z = 0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
        end else begin
            n_edges++;
            idx     = ((n_edges - 1) / SD) % 4;
            exp_an  = 4'b1111 & ~(4'b0001 << idx);
            exp_seg = (idx == 3) ? 7'b1111111 : refSeg(m_snap[idx*4 +: 4]);
            exp_dp  = (idx != 2);
`ifdef TIMER_DISPLAY_BLINK_EN
            if (!z) begin
                wraps_z = 0;
            end else if (((wraps_z / BF) % 2) == 1) begin
                exp_an = 4'b1111;
            end
`endif
            if ((n_edges % FRAME) == 0) begin
                m_snap = {m, d, u};
                if (z) wraps_z++;
            end
        end
        #1;
        checkOutput("an", {3'b000, an}, {3'b000, exp_an});
        checkOutput("seg", seg, exp_seg);
        checkOutput("dp_n", {6'd0, dp_n}, {6'd0, exp_dp});
    endtask

    initial begin
        logic [3:0] u, d, m;
        logic       z;
        $display("[TB] timer_display bench start");

        // Reset held for three edges, then release.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

        // 1:50 for three frames.
        for (int i = 0; i < 3 * FRAME; i++) applyStimulus(1'b1, 4'd0, 4'd5, 4'd1, 1'b0);

        // Units 9 for a frame and a bit, then 8 mid-frame.
        for (int i = 0; i < FRAME + SD + 2; i++) applyStimulus(1'b1, 4'd9, 4'd5, 4'd1, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b1, 4'd8, 4'd5, 4'd1, 1'b0);

        // Out-of-range tens digit shows a dash.
        for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b1, 4'd3, 4'hC, 4'd2, 1'b0);

        // Single-cycle reset in the middle of the minutes digit.
        while (((n_edges / SD) % 4) != 2) applyStimulus(1'b1, 4'd7, 4'd4, 4'd3, 1'b0);
        applyStimulus(1'b1, 4'd7, 4'd4, 4'd3, 1'b0);
        applyStimulus(1'b0, 4'd7, 4'd4, 4'd3, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b1, 4'd7, 4'd4, 4'd3, 1'b0);

        // zero held high for eight frames, then dropped.
        for (int i = 0; i < 8 * FRAME; i++) applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0);

        // Randomised inputs, zero and occasional resets.
        u = 4'd0; d = 4'd0; m = 4'd0; z = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) u = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) m = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) z = ~z;
            applyStimulus(($urandom_range(0, 299) != 0), u, d, m, z);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
